i2c_slave_regfile: RTL and testbench

//  Fully synchronous I2C slave with an addressable bank of NREGS 8-bit registers.
//  SCL/SDA are oversampled on clk and passed through a glitch filter; no combinational loops.

---
 rtl/i2c_slave_regfile.sv | 197 +++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a bank of NREGS 8-bit registers; pointer-based writes and
// auto-incrementing sequential reads. SCL/SDA are synchronised and glitch filtered on clk.
//
// state  | meaning
// IDLE   | bus free, waiting for START
// ADDR   | shifting in address + R/W
// ACK_A  | acknowledging our address
// PTR    | shifting in register pointer
// ACK_P  | acknowledging pointer byte
// WDATA  | shifting in write data
// ACK_W  | committing write data, acknowledging
// RDATA  | shifting out reg[ptr]
// RACK   | sampling master ACK/NACK after read byte
// WAIT_P | not addressed / read finished; ignore bus until START or STOP
module i2c_slave_regfile #(
   parameter logic [6:0] I2C_ADR = 7'h39,
   parameter int         NREGS   = 4,
   parameter int         AW      = 2,
   parameter int         FILTER  = 3,
   parameter logic [7:0] RST_VAL = 8'hFF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 scl_in,
   input  logic                 sda_in,
   output logic                 sda_oe,
   output logic [8*NREGS-1:0]   regs_out,
   output logic                 wr_stb,
   output logic [AW-1:0]        wr_idx,
   output logic                 busy
);

   localparam int FW = (FILTER < 2) ? 1 : $clog2(FILTER);

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_W, RDATA, RACK, WAIT_P
   } state_t;

   state_t        state, state_nx;
   logic [1:0]    s1, s2, flt, prev;
   logic [FW-1:0] fcnt [2];
   logic          scl_f, sda_f, scl_p, sda_p;
   logic          scl_rise, scl_fall, start_c, stop_c;
   logic [3:0]    cnt;
   logic [7:0]    shift;
   logic [7:0]    byte_full;
   logic          addr_match;
   logic [AW-1:0] ptr, ptr_inc;
   logic [7:0]    regs [NREGS];

   // bit 1 = SCL, bit 0 = SDA; filtered level flips after FILTER equal differing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 2'b11;
         s2   <= 2'b11;
         flt  <= 2'b11;
         prev <= 2'b11;
         for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         s1   <= {scl_in, sda_in};
         s2   <= s1;
         prev <= flt;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == flt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILTER - 1)) begin
               flt[i]  <= s2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign scl_f    = flt[1];
   assign sda_f    = flt[0];
   assign scl_p    = prev[1];
   assign sda_p    = prev[0];
   assign scl_rise = scl_f & ~scl_p;
   assign scl_fall = ~scl_f & scl_p;
   assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
   assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

   assign byte_full  = {shift[6:0], sda_f};
   assign addr_match = (byte_full[7:1] == I2C_ADR) && (byte_full[7:1] != 7'd0);
   assign ptr_inc    = ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // ACK slots: cnt==8 marks the fall before the 9th clock, cnt==0 the fall after it
   always_comb begin
      state_nx = state;
      if (start_c) begin
         state_nx = ADDR;
      end else if (stop_c) begin
         state_nx = IDLE;
      end else begin
         case (state)
            ADDR:   if (scl_rise && cnt == 4'd7) state_nx = addr_match ? ACK_A : WAIT_P;
            ACK_A:  if (scl_fall && cnt == 4'd0) state_nx = shift[0] ? RDATA : PTR;
            PTR:    if (scl_rise && cnt == 4'd7) state_nx = ACK_P;
            ACK_P:  if (scl_fall && cnt == 4'd0) state_nx = WDATA;
            WDATA:  if (scl_rise && cnt == 4'd7) state_nx = ACK_W;
            ACK_W:  if (scl_fall && cnt == 4'd0) state_nx = WDATA;
            RDATA:  if (scl_rise && cnt == 4'd7) state_nx = RACK;
            RACK: begin
               if (scl_rise && sda_f)                state_nx = WAIT_P;
               else if (scl_fall && cnt == 4'd0)     state_nx = RDATA;
            end
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         shift  <= '0;
         ptr    <= '0;
         sda_oe <= 1'b0;
         wr_stb <= 1'b0;
         wr_idx <= '0;
         busy   <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= RST_VAL;
      end else begin
         wr_stb <= 1'b0;
         if (start_c) begin
            cnt    <= '0;
            sda_oe <= 1'b0;
         end else if (stop_c) begin
            cnt    <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     shift <= byte_full;
                     cnt   <= cnt + 4'd1;
                     if (state == ADDR && cnt == 4'd7) busy <= addr_match;
                  end
               end
               ACK_A, ACK_P, ACK_W: begin
                  if (scl_rise) cnt <= '0;
                  if (scl_fall && cnt == 4'd8) begin
                     sda_oe <= 1'b1;
                     if (state == ACK_P) ptr <= shift[AW-1:0];
                     if (state == ACK_W) begin
                        regs[ptr] <= shift;
                        wr_stb    <= 1'b1;
                        wr_idx    <= ptr;
                        ptr       <= ptr_inc;
                     end
                  end
                  if (scl_fall && cnt == 4'd0) begin
                     if (state == ACK_A && shift[0]) begin
                        shift  <= regs[ptr];
                        sda_oe <= ~regs[ptr][7];
                     end else begin
                        sda_oe <= 1'b0;
                     end
                  end
               end
               RDATA: begin
                  if (scl_rise) cnt <= cnt + 4'd1;
                  if (scl_fall) begin
                     shift  <= {shift[6:0], 1'b0};
                     sda_oe <= ~shift[6];
                  end
               end
               RACK: begin
                  if (scl_fall && cnt == 4'd8) sda_oe <= 1'b0;
                  if (scl_rise) begin
                     cnt <= '0;
                     if (sda_f) ptr <= ptr_inc;
                  end
                  if (scl_fall && cnt == 4'd0) begin
                     ptr    <= ptr_inc;
                     shift  <= regs[ptr_inc];
                     sda_oe <= ~regs[ptr_inc][7];
                  end
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_out
      assign regs_out[8*g +: 8] = regs[g];
   end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged master with open-drain SDA model.
module tb_i2c_slave_regfile;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        scl_m, sda_m;
   logic        scl_in, sda_in;
   logic        sda_oe;
   logic [31:0] regs_out;
   logic        wr_stb;
   logic [1:0]  wr_idx;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int stb_total = 0;
   int oe_total = 0;
   int busy_total = 0;
   logic [1:0] last_idx = 2'd0;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_regfile dut (
      .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .regs_out(regs_out), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
   );

   always @(negedge clk) begin
      if (wr_stb === 1'b1) begin
         stb_total++;
         last_idx = wr_idx;
      end
      if (sda_oe === 1'b1) oe_total++;
      if (busy === 1'b1) busy_total++;
   end

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b1; wq(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, input int glitch, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i];
         if (i == glitch) begin
            wq(4); scl_m = 1'b1; wq(1); scl_m = 1'b0; wq(Q - 5);
         end else begin
            wq(Q);
         end
         scl_m = 1'b1; wq(2 * Q);
         scl_m = 1'b0; wq(Q);
      end
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      ack = sda_in; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] b);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         wq(Q);
         scl_m = 1'b1; wq(Q);
         b[i] = sda_in; wq(Q);
         scl_m = 1'b0; wq(Q);
      end
      sda_m = nack; wq(Q);
      scl_m = 1'b1; wq(2 * Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic test_reset;
      reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      wq(5);
      reset = 1'b0;
      wq(3);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb got %b exp 0", wr_stb); end
      checks++; if (wr_idx !== 2'd0) begin errors++; $display("FAIL reset_wr_idx got %0d exp 0", wr_idx); end
      checks++; if (regs_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_regs got %h exp ffffffff", regs_out); end
   endtask

   task automatic test_single_write;
      logic a0, a1, a2;
      int s0;
      s0 = stb_total;
      i2c_start;
      wr_byte(8'h72, -1, a0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL w1_busy_mid got %b exp 1", busy); end
      wr_byte(8'h01, -1, a1);
      wr_byte(8'hA5, -1, a2);
      i2c_stop; wq(Q);
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL w1_acks got %b exp 000", {a0, a1, a2}); end
      checks++; if (regs_out !== 32'hFFFF_A5FF) begin errors++; $display("FAIL w1_regs got %h exp ffffa5ff", regs_out); end
      checks++; if (stb_total - s0 !== 1) begin errors++; $display("FAIL w1_stb_count got %0d exp 1", stb_total - s0); end
      checks++; if (last_idx !== 2'd1) begin errors++; $display("FAIL w1_wr_idx got %0d exp 1", last_idx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL w1_busy_after got %b exp 0", busy); end
   endtask

   task automatic test_write_wrap;
      logic a0, a1, a2, a3;
      int s0;
      s0 = stb_total;
      i2c_start;
      wr_byte(8'h72, -1, a0);
      wr_byte(8'h03, -1, a1);
      wr_byte(8'h11, -1, a2);
      wr_byte(8'h22, -1, a3);
      i2c_stop; wq(Q);
      checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL w2_acks got %b exp 0000", {a0, a1, a2, a3}); end
      checks++; if (regs_out !== 32'h11FF_A522) begin errors++; $display("FAIL w2_regs got %h exp 11ffa522", regs_out); end
      checks++; if (stb_total - s0 !== 2) begin errors++; $display("FAIL w2_stb_count got %0d exp 2", stb_total - s0); end
      checks++; if (last_idx !== 2'd0) begin errors++; $display("FAIL w2_wr_idx got %0d exp 0", last_idx); end
   endtask

   task automatic test_read_rstart;
      logic a0, a1, a2;
      logic [7:0] d0, d1;
      i2c_start;
      wr_byte(8'h72, -1, a0);
      wr_byte(8'h02, -1, a1);
      i2c_start;
      wr_byte(8'h73, -1, a2);
      rd_byte(1'b0, d0);
      rd_byte(1'b1, d1);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL r1_oe_after_nack got %b exp 0", sda_oe); end
      i2c_stop; wq(Q);
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL r1_acks got %b exp 000", {a0, a1, a2}); end
      checks++; if (d0 !== 8'hFF) begin errors++; $display("FAIL r1_byte0 got %h exp ff", d0); end
      checks++; if (d1 !== 8'h11) begin errors++; $display("FAIL r1_byte1 got %h exp 11", d1); end
   endtask

   task automatic test_read_wrap;
      logic a0;
      logic [7:0] d0, d1;
      i2c_start;
      wr_byte(8'h73, -1, a0);
      rd_byte(1'b0, d0);
      rd_byte(1'b1, d1);
      i2c_stop; wq(Q);
      checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL r2_ack got %b exp 0", a0); end
      checks++; if (d0 !== 8'h22) begin errors++; $display("FAIL r2_byte0 got %h exp 22", d0); end
      checks++; if (d1 !== 8'hA5) begin errors++; $display("FAIL r2_byte1 got %h exp a5", d1); end
   endtask

   task automatic test_mismatch;
      logic a0, a1, a2, a3;
      int o0, b0, s0;
      o0 = oe_total; b0 = busy_total; s0 = stb_total;
      i2c_start;
      wr_byte(8'h70, -1, a0);
      wr_byte(8'h01, -1, a1);
      wr_byte(8'h55, -1, a2);
      i2c_stop; wq(Q);
      i2c_start;
      wr_byte(8'h00, -1, a3);
      i2c_stop; wq(Q);
      checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL nm_acks got %b exp 1111", {a0, a1, a2, a3}); end
      checks++; if (oe_total - o0 !== 0) begin errors++; $display("FAIL nm_oe_cycles got %0d exp 0", oe_total - o0); end
      checks++; if (busy_total - b0 !== 0) begin errors++; $display("FAIL nm_busy_cycles got %0d exp 0", busy_total - b0); end
      checks++; if (stb_total - s0 !== 0) begin errors++; $display("FAIL nm_stb_count got %0d exp 0", stb_total - s0); end
      checks++; if (regs_out !== 32'h11FF_A522) begin errors++; $display("FAIL nm_regs got %h exp 11ffa522", regs_out); end
   endtask

   task automatic test_glitch;
      logic a0, a1, a2;
      int s0;
      s0 = stb_total;
      i2c_start;
      wr_byte(8'h72, -1, a0);
      wr_byte(8'h02, -1, a1);
      wr_byte(8'h3C, 3, a2);
      i2c_stop; wq(Q);
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL gl_acks got %b exp 000", {a0, a1, a2}); end
      checks++; if (regs_out !== 32'h113C_A522) begin errors++; $display("FAIL gl_regs got %h exp 113ca522", regs_out); end
      checks++; if (stb_total - s0 !== 1) begin errors++; $display("FAIL gl_stb_count got %0d exp 1", stb_total - s0); end
      checks++; if (last_idx !== 2'd2) begin errors++; $display("FAIL gl_wr_idx got %0d exp 2", last_idx); end
   endtask

   task automatic test_reset_mid_read;
      logic a0, a1, a2, a3;
      int s0;
      i2c_start;
      wr_byte(8'h73, -1, a0);
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rr_oe_before got %b exp 1", sda_oe); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rr_oe_after got %b exp 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b exp 0", busy); end
      checks++; if (regs_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rr_regs got %h exp ffffffff", regs_out); end
      reset = 1'b0;
      sda_m = 1'b1; scl_m = 1'b1; wq(Q);
      s0 = stb_total;
      i2c_start;
      wr_byte(8'h72, -1, a1);
      wr_byte(8'h00, -1, a2);
      wr_byte(8'h5A, -1, a3);
      i2c_stop; wq(Q);
      checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL rr_acks got %b exp 0000", {a0, a1, a2, a3}); end
      checks++; if (regs_out !== 32'hFFFF_FF5A) begin errors++; $display("FAIL rr_regs_new got %h exp ffffff5a", regs_out); end
      checks++; if (stb_total - s0 !== 1) begin errors++; $display("FAIL rr_stb_count got %0d exp 1", stb_total - s0); end
      checks++; if (last_idx !== 2'd0) begin errors++; $display("FAIL rr_wr_idx got %0d exp 0", last_idx); end
   endtask

   initial begin
      test_reset;
      test_single_write;
      test_write_wrap;
      test_read_rstart;
      test_read_wrap;
      test_mismatch;
      test_glitch;
      test_reset_mid_read;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
